// File: rtl/riscv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_pkg : shared RV32 constants and fetch FSM state encoding | Rev 1.0
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0040_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE     = 2'd0,
    FETCH_WAIT_RSP = 2'd1,
    FETCH_DROP     = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_skid_buffer : one-entry {instruction, pc} holding slot | Rev 1.0
// ---------------------------------------------------------------------------
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_instr,
  input  logic [XLEN-1:0] push_pc,
  output logic            full,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  logic            r_full;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  // Push wins over pop so a simultaneous pop+push keeps the slot occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (flush) begin
      r_full  <= 1'b0;
    end else if (push) begin
      r_full  <= 1'b1;
      r_instr <= push_instr;
      r_pc    <= push_pc;
    end else if (pop) begin
      r_full  <= 1'b0;
    end
  end

  assign full  = r_full;
  assign instr = r_instr;
  assign pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : single-outstanding instruction fetch with IF/ID register and
// skid buffer; optional stall counter via FETCH_PERF_CNT_EN | Rev 1.0
// ---------------------------------------------------------------------------
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instruction,
  output logic [XLEN-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_stall_cnt
`endif
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tag;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_instr;
  logic [XLEN-1:0] r_if_pc;

  logic            w_skid_full;
  logic [XLEN-1:0] w_skid_instr;
  logic [XLEN-1:0] w_skid_pc;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_deliver;
  logic            w_if_load;
  logic            w_skid_push;
  logic            w_skid_pop;
  logic            w_grant;

  assign w_redirect_pc = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
  assign w_deliver     = (r_state == FETCH_WAIT_RSP) && imem_rvalid && !redirect_valid;
  assign w_if_load     = !r_if_valid || !id_stall;
  // The skid slot is empty whenever a request is in flight, so push-while-full
  // only ever occurs together with a pop.
  assign w_skid_push   = w_deliver && (!w_if_load || w_skid_full);
  assign w_skid_pop    = w_if_load && w_skid_full && !redirect_valid;

  assign imem_req  = rst_n && (r_state == FETCH_IDLE) && !w_skid_full && !redirect_valid;
  assign imem_addr = r_pc;
  assign w_grant   = imem_req && imem_gnt;

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (w_skid_push),
    .pop        (w_skid_pop),
    .push_instr (imem_rdata),
    .push_pc    (r_tag),
    .full       (w_skid_full),
    .instr      (w_skid_instr),
    .pc         (w_skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_IDLE;
      r_pc    <= RESET_PC;
      r_tag   <= '0;
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
          end else if (w_grant) begin
            r_tag   <= r_pc;
            r_pc    <= r_pc + XLEN'(4);
            r_state <= FETCH_WAIT_RSP;
          end
        end
        FETCH_WAIT_RSP: begin
          if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= imem_rvalid ? FETCH_IDLE : FETCH_DROP;
          end else if (imem_rvalid) begin
            r_state <= FETCH_IDLE;
          end
        end
        FETCH_DROP: begin
          if (redirect_valid) r_pc <= w_redirect_pc;
          if (imem_rvalid)    r_state <= FETCH_IDLE;
        end
        default: r_state <= FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
      r_if_pc    <= '0;
    end else if (redirect_valid) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
    end else if (w_if_load) begin
      if (w_skid_full) begin
        r_if_valid <= 1'b1;
        r_if_instr <= w_skid_instr;
        r_if_pc    <= w_skid_pc;
      end else if (w_deliver) begin
        r_if_valid <= 1'b1;
        r_if_instr <= imem_rdata;
        r_if_pc    <= r_tag;
      end else begin
        r_if_valid <= 1'b0;
        r_if_instr <= NOP_INSTR;
      end
    end
  end

  assign if_valid       = r_if_valid;
  assign if_instruction = r_if_instr;
  assign if_pc          = r_if_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_if_valid && id_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + XLEN'(1);
    end
  end

  assign fetch_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_stage : randomized fetch traffic against a queue-based model | Rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] C_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (C_RESET_PC),
    .NOP_INSTR (C_NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_stall_cnt(fetch_stall_cnt)
`endif
  );

  // Reference model: held = instructions sitting in IF/ID (front) and skid.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  item_t       held[$];
  logic [31:0] m_pc;
  logic [31:0] m_tag;
  bit          m_outst;
  bit          m_stale;
  logic [31:0] m_cnt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    held.delete();
    m_pc    = C_RESET_PC;
    m_tag   = '0;
    m_outst = 0;
    m_stale = 0;
    m_cnt   = '0;
  endtask

  task automatic step(input bit gnt, input bit rv, input logic [31:0] rd,
                      input bit rd_v, input logic [31:0] rpc, input bit stall);
    bit exp_req;
    @(negedge clk);
    imem_gnt       = gnt;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    redirect_valid = rd_v;
    redirect_pc    = rpc;
    id_stall       = stall;
    #1;
    exp_req = !m_outst && (held.size() < 2) && !rd_v;
    check("imem_req", imem_req, exp_req);
    check("imem_addr", imem_addr, m_pc);
    check("if_valid", if_valid, held.size() > 0);
    if (held.size() > 0) begin
      check("if_pc", if_pc, held[0].pc);
      check("if_instruction", if_instruction, held[0].instr);
    end else begin
      check("if_nop", if_instruction, C_NOP);
    end
`ifdef FETCH_PERF_CNT_EN
    check("fetch_stall_cnt", fetch_stall_cnt, m_cnt);
`endif
    @(posedge clk);
    if ((held.size() > 0) && stall && (m_cnt != 32'hFFFF_FFFF)) m_cnt++;
    if (rd_v) begin
      held.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
      if (m_outst) begin
        if (rv) begin
          m_outst = 0;
          m_stale = 0;
        end else begin
          m_stale = 1;
        end
      end
    end else begin
      if ((held.size() > 0) && !stall) void'(held.pop_front());
      if (m_outst && rv) begin
        if (!m_stale) held.push_back({rd, m_tag});
        m_outst = 0;
        m_stale = 0;
      end
      if (exp_req && gnt) begin
        m_outst = 1;
        m_tag   = m_pc;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  task automatic rand_step(input int gnt_pct, input int rv_pct, input int stall_pct,
                           input int redir_pct);
    logic [31:0] tgt;
    int          sel;
    sel = $urandom_range(0, 9);
    tgt = (sel == 0) ? 32'hFFFF_FFFC : (sel == 1) ? 32'h0000_0102 : 32'($urandom);
    step($urandom_range(0, 99) < gnt_pct,
         m_outst && ($urandom_range(0, 99) < rv_pct),
         32'($urandom),
         $urandom_range(0, 99) < redir_pct,
         tgt,
         $urandom_range(0, 99) < stall_pct);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_stall       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, C_RESET_PC);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instruction", if_instruction, C_NOP);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: always granted, response one cycle later, no stalls.
    repeat (40) step(1'b1, m_outst, 32'($urandom), 1'b0, '0, 1'b0);
    // Stall burst while a response is returning.
    repeat (6) step(1'b1, m_outst, 32'($urandom), 1'b0, '0, 1'b1);
    repeat (10) step(1'b1, m_outst, 32'($urandom), 1'b0, '0, 1'b0);
    // Redirect into wrap-around, then one to a misaligned target mid-request.
    step(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    repeat (6) step(1'b1, m_outst, 32'($urandom), 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h0000_0102, 1'b0);
    repeat (6) step(1'b1, m_outst, 32'($urandom), 1'b0, '0, 1'b0);

    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 400; i++) begin
        case (ph)
          0:       rand_step(70, 50, 10, 0);
          1:       rand_step(80, 60, 60, 3);
          2:       rand_step(50, 40, 30, 15);
          default: rand_step(90, 90, 90, 5);
        endcase
      end
    end

    // Reset in the middle of traffic; a late response must then be ignored.
    repeat (3) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    id_stall       = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_imem_req", imem_req, 1'b0);
    check("midrst_imem_addr", imem_addr, C_RESET_PC);
    check("midrst_if_valid", if_valid, 1'b0);
    check("midrst_if_instruction", if_instruction, C_NOP);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    repeat (200) rand_step(70, 50, 30, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
